alu_result_serializer: RTL and testbench

Downstream stage of the synchronous ALU. Captures each registered result/status pair the ALU produces and transmits it as a framed, parity-protected serial bitstream on one output line. A one-entry holding register absorbs a capture that arrives while a frame is in flight. Further captures in that window are dropped and flagged.

---
 rtl/alu_ser_pkg.sv | 9 +
 rtl/alu_result_hold.sv | 22 ++
 rtl/alu_result_serializer.sv | 98 +++++++++
 tb/tb_alu_result_serializer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_ser_pkg.sv
// alu_ser_pkg: shared status indices, preamble and FSM state type for the ALU result serializer
package alu_ser_pkg;
    localparam int ERROR = 3;
    localparam int NOT_EVEN_1 = 2;
    localparam int ZEROS = 1;
    localparam int OVERFLOW = 0;
    localparam logic [1:0] PREAMBLE = 2'b10;
    typedef enum logic [2:0] {IDLE, PRE, STAT, DATA, PAR} ser_state_t;
endpackage

// File: rtl/alu_result_hold.sv
// alu_result_hold: one-entry holding register with write, read and full flag
module alu_result_hold #(
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         wr_en,
    input  logic         rd_en,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full
);
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            full  <= 1'b0;
            rdata <= '0;
        end else begin
            full <= wr_en | (full & ~rd_en);
            if (wr_en) rdata <= wdata;
        end
    end
endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: frames each ALU result/status capture as a parity-protected serial bitstream
module alu_result_serializer
    import alu_ser_pkg::*;
#(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_valid,
    input  logic [M-1:0] i_result,
    input  logic [3:0]   i_status,
    input  logic         i_clr_ovr,
    output logic         o_sout,
    output logic         o_frame,
    output logic         o_done,
    output logic         o_busy,
    output logic         o_overrun
);
    localparam int W = M + 4;
    localparam int CW = ($clog2(M) < 2) ? 2 : $clog2(M);
    ser_state_t state;
    logic [W-1:0] sh, hold_data, load_data;
    logic [CW-1:0] cnt;
    logic err, par, hold_full, idle, hold_rd, hold_wr, drop, tx_bit;
    assign idle = state == IDLE;
    // In IDLE the hold entry drains first, so a new capture may refill it in the same edge
    assign hold_rd = idle & hold_full;
    assign hold_wr = i_valid & (idle ? hold_full : ~hold_full);
    assign drop = i_valid & ~idle & hold_full;
    assign load_data = hold_full ? hold_data : {i_status, i_result};
    always_comb tx_bit = (state == PRE) ? PREAMBLE[~cnt[0]] : (state == PAR) ? par : idle ? 1'b1 : sh[W-1];
    alu_result_hold #(.W(W)) u_hold (
        .clk     (clk),
        .i_reset (i_reset),
        .wr_en   (hold_wr),
        .rd_en   (hold_rd),
        .wdata   ({i_status, i_result}),
        .rdata   (hold_data),
        .full    (hold_full)
    );
    // Outputs trail the state by one cycle, so o_busy also covers the bit still on the line
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            par       <= 1'b0;
            o_sout    <= 1'b1;
            o_frame   <= 1'b0;
            o_done    <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_sout    <= tx_bit;
            o_frame   <= ~idle;
            o_done    <= idle & o_frame;
            o_busy    <= ~idle | hold_full | o_frame;
            o_overrun <= drop | (o_overrun & ~i_clr_ovr);
            case (state)
                IDLE: if (hold_full | i_valid) begin
                    sh    <= load_data;
                    err   <= load_data[M+ERROR];
                    par   <= 1'b0;
                    cnt   <= '0;
                    state <= PRE;
                end
                PRE: begin
                    cnt <= cnt + 1'b1;
                    if (cnt[0]) begin
                        cnt   <= '0;
                        state <= STAT;
                    end
                end
                STAT: begin
                    sh  <= sh << 1;
                    par <= par ^ sh[W-1];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(3)) begin
                        cnt   <= '0;
                        state <= err ? PAR : DATA;
                    end
                end
                DATA: begin
                    sh  <= sh << 1;
                    par <= par ^ sh[W-1];
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(M - 1)) begin
                        cnt   <= '0;
                        state <= PAR;
                    end
                end
                PAR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: directed checks of framing, hold/overrun, reset abort and M=32 framing
module tb_alu_result_serializer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic i_reset, i_valid, i_clr_ovr, v32, sel32;
    logic [7:0] i_result;
    logic [3:0] i_status, s32;
    logic [31:0] r32;
    logic sout8, frame8, done8, busy8, ovr8, sout32, frame32, done32, busy32, ovr32;
    logic sout, frame, done, busy, ovr;
    logic [63:0] cap;
    int n_chk, n_fail, ncap, ndone, last_ticks;
    assign sout  = sel32 ? sout32  : sout8;
    assign frame = sel32 ? frame32 : frame8;
    assign done  = sel32 ? done32  : done8;
    assign busy  = sel32 ? busy32  : busy8;
    assign ovr   = sel32 ? ovr32   : ovr8;
    alu_result_serializer #(.M(8)) dut8 (
        .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_result(i_result), .i_status(i_status),
        .i_clr_ovr(i_clr_ovr), .o_sout(sout8), .o_frame(frame8), .o_done(done8), .o_busy(busy8),
        .o_overrun(ovr8)
    );
    alu_result_serializer #(.M(32)) dut32 (
        .clk(clk), .i_reset(i_reset), .i_valid(v32), .i_result(r32), .i_status(s32),
        .i_clr_ovr(i_clr_ovr), .o_sout(sout32), .o_frame(frame32), .o_done(done32), .o_busy(busy32),
        .o_overrun(ovr32)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk);
        if (frame) begin
            cap = {cap[62:0], sout};
            ncap++;
        end
        if (done) ndone++;
    endtask
    task automatic cap_clear();
        cap = '0;
        ncap = 0;
        ndone = 0;
    endtask
    task automatic send(input logic [7:0] r, input logic [3:0] s);
        i_result = r;
        i_status = s;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask
    task automatic expect_frame(input string tag, input logic [63:0] exp, input int len);
        int t = 0;
        while (ncap < len && t < 200) begin
            tick();
            t++;
        end
        last_ticks = t;
        chk({tag, "_len"}, 64'(ncap), 64'(len));
        chk(tag, cap & ((64'd1 << len) - 64'd1), exp);
    endtask
    initial begin
        n_chk = 0; n_fail = 0; sel32 = 1'b0;
        i_reset = 1'b0; i_valid = 1'b0; i_clr_ovr = 1'b0; i_result = '0; i_status = '0;
        v32 = 1'b0; r32 = '0; s32 = '0;
        cap_clear();
        repeat (2) @(negedge clk);
        chk("rst_sout", 64'(sout), 64'd1);
        chk("rst_frame", 64'(frame), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovr", 64'(ovr), 64'd0);
        i_reset = 1'b1;
        tick();
        // full frame A5 / 0000
        cap_clear();
        send(8'hA5, 4'b0000);
        chk("t1_frame_c0", 64'(frame), 64'd0);
        expect_frame("t1_bits", {2'b10, 4'b0000, 8'hA5, 1'b0}, 15);
        chk("t1_latency", 64'(last_ticks), 64'd15);
        tick();
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_gap_frame", 64'(frame), 64'd0);
        chk("t1_gap_sout", 64'(sout), 64'd1);
        chk("t1_busy16", 64'(busy), 64'd1);
        tick();
        chk("t1_done_off", 64'(done), 64'd0);
        chk("t1_busy17", 64'(busy), 64'd0);
        // short frame on ERROR, result unknown
        cap_clear();
        send(8'hxx, 4'b1000);
        expect_frame("t2_bits", {2'b10, 4'b1000, 1'b1}, 7);
        chk("t2_latency", 64'(last_ticks), 64'd7);
        tick();
        chk("t2_done", 64'(done), 64'd1);
        tick();
        // hold and drop
        cap_clear();
        send(8'h01, 4'b0001);
        tick();
        tick();
        send(8'hFF, 4'b0000);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_ovr_before", 64'(ovr), 64'd0);
        tick();
        send(8'h0F, 4'b0000);
        chk("t3_ovr_set", 64'(ovr), 64'd1);
        expect_frame("t3_first", {2'b10, 4'b0001, 8'h01, 1'b0}, 15);
        cap_clear();
        tick();
        chk("t3_gap_frame", 64'(frame), 64'd0);
        chk("t3_gap_done", 64'(done), 64'd1);
        tick();
        chk("t3_second_start", 64'(frame), 64'd1);
        expect_frame("t3_second", {2'b10, 4'b0000, 8'hFF, 1'b0}, 15);
        tick();
        tick();
        chk("t3_busy_end", 64'(busy), 64'd0);
        chk("t3_ovr_sticky", 64'(ovr), 64'd1);
        i_clr_ovr = 1'b1;
        tick();
        i_clr_ovr = 1'b0;
        chk("t3_ovr_clr", 64'(ovr), 64'd0);
        // reset mid DATA with hold full and overrun set
        cap_clear();
        send(8'h5A, 4'b0000);
        send(8'h33, 4'b0000);
        send(8'h44, 4'b0000);
        chk("t4_ovr_pre", 64'(ovr), 64'd1);
        for (int t = 0; t < 100 && ncap < 10; t++) tick();
        chk("t4_reached", 64'(ncap), 64'd10);
        #2 i_reset = 1'b0;
        #1;
        chk("t4_sout", 64'(sout), 64'd1);
        chk("t4_frame", 64'(frame), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_ovr", 64'(ovr), 64'd0);
        chk("t4_done", 64'(done), 64'd0);
        @(negedge clk);
        i_reset = 1'b1;
        cap_clear();
        repeat (40) tick();
        chk("t4_no_frame", 64'(ncap), 64'd0);
        chk("t4_no_done", 64'(ndone), 64'd0);
        chk("t4_idle_busy", 64'(busy), 64'd0);
        // hold drain plus capture plus clear in the IDLE gap
        cap_clear();
        send(8'h11, 4'b0000);
        send(8'h22, 4'b0000);
        send(8'h55, 4'b0000);
        chk("t5_ovr_set", 64'(ovr), 64'd1);
        expect_frame("t5_a", {2'b10, 4'b0000, 8'h11, 1'b0}, 15);
        cap_clear();
        i_clr_ovr = 1'b1;
        send(8'h3C, 4'b0000);
        i_clr_ovr = 1'b0;
        chk("t5_gap_done", 64'(done), 64'd1);
        chk("t5_ovr_clr", 64'(ovr), 64'd0);
        expect_frame("t5_b", {2'b10, 4'b0000, 8'h22, 1'b0}, 15);
        cap_clear();
        expect_frame("t5_c", {2'b10, 4'b0000, 8'h3C, 1'b0}, 15);
        chk("t5_ovr_end", 64'(ovr), 64'd0);
        repeat (3) tick();
        // M=32 frame
        sel32 = 1'b1;
        cap_clear();
        r32 = 32'h8000_0001;
        s32 = 4'b0100;
        v32 = 1'b1;
        tick();
        v32 = 1'b0;
        expect_frame("t6_bits", {2'b10, 4'b0100, 32'h8000_0001, 1'b1}, 39);
        chk("t6_latency", 64'(last_ticks), 64'd39);
        tick();
        chk("t6_done", 64'(done), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
